// File: rtl/exwb_pkg.sv
// exwb_pkg: types and constants shared by the execute-to-writeback register
// and the writeback stage.
//   EX_WB         - result bundle handed from execute to writeback
//   OPC_MUL       - opcode that writes regfile[0] and regfile[2]
//   OPC_STORE     - MOV-store opcode, completes only on store_writebackFlag
//   fifo_state_e  - occupancy state of the 2-entry skid FIFO
//   dest_mask()   - set of architectural registers an entry will write
package exwb_pkg;

    localparam int NREGS = 16;
    localparam int DEPTH = 2;

    localparam logic [7:0] OPC_MUL   = 8'd247;
    localparam logic [7:0] OPC_STORE = 8'd137;

    typedef struct packed {
        logic [7:0]  ctl_opcode;
        logic [7:0]  ctl_regByte;
        logic [7:0]  ctl_rmByte;
        logic [31:0] result;
        logic        sim_end;
    } EX_WB;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

    // Only the low nibble of a register byte names one of the 16 registers.
    function automatic logic [0:NREGS-1] dest_mask(input EX_WB e);
        logic [0:NREGS-1] m;
        m = '0;
        if (e.ctl_opcode == OPC_MUL) begin
            m[0] = 1'b1;
            m[2] = 1'b1;
        end else if (e.ctl_opcode == OPC_STORE) begin
            m[e.ctl_regByte[3:0]] = 1'b1;
        end else begin
            m[e.ctl_rmByte[3:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mod_exwb_fifo2.sv
// mod_exwb_fifo2: generic 2-entry skid FIFO.
// Each entry holds a payload (head only is visible) and a tag (visible for
// both entries, so the parent can summarise everything buffered).
// Handshake: an entry is written when push_i is high and ready_o is high;
// the head is removed when pop_i is high and valid_o is high. Both may
// happen in the same cycle.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   push_i, data_i, tag_i - write request with payload and tag
//   pop_i             - remove the head entry
//   ready_o           - FIFO has room (state != FULL)
//   valid_o           - FIFO holds at least one entry
//   count_o           - occupancy 0..2 (doubles as the FSM state)
//   head_o, head_tag_o, tail_tag_o - registered entry contents
module mod_exwb_fifo2
    import exwb_pkg::*;
#(
    parameter int W = 8,
    parameter int T = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic [T-1:0] tag_i,
    input  logic         pop_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o,
    output logic [T-1:0] head_tag_o,
    output logic [T-1:0] tail_tag_o
);

    fifo_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [T-1:0] htag_q, htag_d;
    logic [T-1:0] ttag_q, ttag_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        htag_d  = htag_q;
        ttag_d  = ttag_q;
        do_push = push_i && (state_q != ST_FULL);
        do_pop  = pop_i && (state_q != ST_EMPTY);
        case (state_q)
            ST_EMPTY: begin
                if (do_push) begin
                    head_d  = data_i;
                    htag_d  = tag_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (do_push && do_pop) begin
                    // Head leaves while the new entry takes its place.
                    head_d = data_i;
                    htag_d = tag_i;
                end else if (do_push) begin
                    tail_d  = data_i;
                    ttag_d  = tag_i;
                    state_d = ST_FULL;
                end else if (do_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (do_pop) begin
                    head_d  = tail_q;
                    htag_d  = ttag_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            htag_q  <= '0;
            ttag_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            htag_q  <= htag_d;
            ttag_q  <= ttag_d;
        end
    end

    assign ready_o    = (state_q != ST_FULL);
    assign valid_o    = (state_q != ST_EMPTY);
    assign count_o    = state_q;
    assign head_o     = head_q;
    assign head_tag_o = htag_q;
    assign tail_tag_o = ttag_q;

endmodule

// File: rtl/mod_exwb_stage.sv
// mod_exwb_stage: execute-to-writeback pipeline register.
// Buffers up to two execute results and presents the oldest to writeback.
// Handshake: execute transfers ex_data on a cycle where ex_valid and ex_ready
// are both high; writeback consumes exwb on a cycle where can_writeback is
// high and wb_accept (or store_writebackFlag for an OPC_STORE head) is high.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   ex_valid, ex_data     - execute result offer
//   ex_ready              - stage can take ex_data this cycle
//   can_writeback, exwb   - oldest entry, zero while empty
//   wb_accept             - writeback consumed a non-store head
//   store_writebackFlag   - writeback completed a store head
//   pending_mask          - registers still owed a write by buffered entries
//   sim_end_seen          - a sim_end entry has been accepted
module mod_exwb_stage
    import exwb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  EX_WB             ex_data,
    output logic             ex_ready,
    output logic             can_writeback,
    output EX_WB             exwb,
    input  logic             wb_accept,
    input  logic             store_writebackFlag,
    output logic [0:NREGS-1] pending_mask,
    output logic             sim_end_seen
);

    logic             fifo_ready;
    logic             fifo_valid;
    logic [1:0]       fifo_count;
    EX_WB             head_data;
    logic [NREGS-1:0] head_tag;
    logic [NREGS-1:0] tail_tag;
    logic             push;
    logic             pop;
    logic             sim_end_q, sim_end_d;

    assign ex_ready = fifo_ready && !sim_end_q;
    assign push     = ex_valid && ex_ready;

    // A store head waits for the store completion flag; wb_accept is not enough.
    assign pop = can_writeback &&
                 ((exwb.ctl_opcode == OPC_STORE) ? store_writebackFlag : wb_accept);

    always_comb begin
        sim_end_d = sim_end_q;
        if (push && ex_data.sim_end) begin
            sim_end_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sim_end_q <= 1'b0;
        end else begin
            sim_end_q <= sim_end_d;
        end
    end

    mod_exwb_fifo2 #(
        .W ($bits(EX_WB)),
        .T (NREGS)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .data_i     (ex_data),
        .tag_i      (dest_mask(ex_data)),
        .pop_i      (pop),
        .ready_o    (fifo_ready),
        .valid_o    (fifo_valid),
        .count_o    (fifo_count),
        .head_o     (head_data),
        .head_tag_o (head_tag),
        .tail_tag_o (tail_tag)
    );

    assign can_writeback = fifo_valid;
    assign exwb          = fifo_valid ? head_data : '0;
    assign sim_end_seen  = sim_end_q;

    // Built only from stored masks, so it changes on the same edge as push/pop.
    assign pending_mask = (fifo_valid ? head_tag : '0) |
                          ((fifo_count == 2'd2) ? tail_tag : '0);

endmodule

// File: tb/tb_mod_exwb_stage.sv
module tb_mod_exwb_stage;
  import exwb_pkg::*;

  logic             clk;
  logic             reset;
  logic             ex_valid;
  EX_WB             ex_data;
  logic             ex_ready;
  logic             can_writeback;
  EX_WB             exwb;
  logic             wb_accept;
  logic             store_writebackFlag;
  logic [0:NREGS-1] pending_mask;
  logic             sim_end_seen;

  int checks;
  int failures;
  logic [$bits(EX_WB)-1:0] exp_q[$];

  mod_exwb_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_valid            (ex_valid),
    .ex_data             (ex_data),
    .ex_ready            (ex_ready),
    .can_writeback       (can_writeback),
    .exwb                (exwb),
    .wb_accept           (wb_accept),
    .store_writebackFlag (store_writebackFlag),
    .pending_mask        (pending_mask),
    .sim_end_seen        (sim_end_seen)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic EX_WB mk(input logic [7:0] opc, input logic [7:0] rb,
                              input logic [7:0] rm, input logic se);
    EX_WB e;
    e.ctl_opcode  = opc;
    e.ctl_regByte = rb;
    e.ctl_rmByte  = rm;
    e.result      = 32'($urandom_range(0, 32'hffff));
    e.sim_end     = se;
    return e;
  endfunction

  function automatic logic [0:NREGS-1] m1(input int r);
    logic [0:NREGS-1] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // driver: offer an entry; when it is going to be accepted, expect it later
  task automatic offer(input EX_WB e, input bit accepted);
    ex_valid = 1'b1;
    ex_data  = e;
    if (accepted) exp_q.push_back(e);
  endtask

  task automatic idle_in();
    ex_valid = 1'b0;
    ex_data  = '0;
  endtask

  // scoreboard monitor: a consumption is visible before the edge that pops
  always @(negedge clk) begin
    if (!reset && can_writeback &&
        ((exwb.ctl_opcode == OPC_STORE) ? store_writebackFlag : wb_accept)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop act=%0h exp=none", exwb);
      end else begin
        chk("pop_data", 64'(exwb), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [0:NREGS-1] m;
    EX_WB e;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    wb_accept = 1'b0;
    store_writebackFlag = 1'b0;
    idle_in();
    tick();
    tick();
    reset = 1'b0;

    // reset then idle
    tick();
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_can_wb", 64'(can_writeback), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_exwb", 64'(exwb), 64'd0);
    chk("rst_sim_end", 64'(sim_end_seen), 64'd0);

    // single entry, then accept
    e = mk(8'h01, 8'h0, 8'd3, 1'b0);
    offer(e, 1);
    tick();
    idle_in();
    chk("one_can_wb", 64'(can_writeback), 64'd1);
    chk("one_rm", 64'(exwb.ctl_rmByte), 64'd3);
    chk("one_pending", 64'(pending_mask), 64'(m1(3)));
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    chk("one_drain_can_wb", 64'(can_writeback), 64'd0);
    chk("one_drain_pending", 64'(pending_mask), 64'd0);

    // MUL then rm=5 -> FULL
    offer(mk(OPC_MUL, 8'd1, 8'd9, 1'b0), 1);
    tick();
    offer(mk(8'h01, 8'd0, 8'd5, 1'b0), 1);
    tick();
    idle_in();
    m = '0;
    m[0] = 1'b1;
    m[2] = 1'b1;
    m[5] = 1'b1;
    chk("full_ex_ready", 64'(ex_ready), 64'd0);
    chk("full_pending", 64'(pending_mask), 64'(m));
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    chk("full_pop_rm", 64'(exwb.ctl_rmByte), 64'd5);
    chk("full_pop_pending", 64'(pending_mask), 64'(m1(5)));
    chk("full_pop_ex_ready", 64'(ex_ready), 64'd1);
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    chk("full_empty", 64'(can_writeback), 64'd0);

    // store waits for store_writebackFlag
    offer(mk(OPC_STORE, 8'd4, 8'd7, 1'b0), 1);
    tick();
    idle_in();
    wb_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("store_held", 64'(can_writeback), 64'd1);
      chk("store_pending", 64'(pending_mask), 64'(m1(4)));
    end
    store_writebackFlag = 1'b1;
    tick();
    store_writebackFlag = 1'b0;
    wb_accept = 1'b0;
    chk("store_popped", 64'(can_writeback), 64'd0);
    chk("store_pending_clr", 64'(pending_mask), 64'd0);

    // non-store head ignores store_writebackFlag
    offer(mk(8'h22, 8'd1, 8'd6, 1'b0), 1);
    tick();
    idle_in();
    store_writebackFlag = 1'b1;
    tick();
    store_writebackFlag = 1'b0;
    chk("nonstore_ignore_flag", 64'(can_writeback), 64'd1);
    chk("nonstore_pending", 64'(pending_mask), 64'(m1(6)));
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    chk("nonstore_drain", 64'(can_writeback), 64'd0);

    // accept while empty is ignored
    wb_accept = 1'b1;
    store_writebackFlag = 1'b1;
    tick();
    wb_accept = 1'b0;
    store_writebackFlag = 1'b0;
    chk("empty_accept_can_wb", 64'(can_writeback), 64'd0);
    chk("empty_accept_ready", 64'(ex_ready), 64'd1);

    // streaming with wb_accept high
    wb_accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(mk(8'h10 + 8'(i), 8'd0, 8'(i + 8), 1'b0), 1);
      tick();
      chk("stream_can_wb", 64'(can_writeback), 64'd1);
      chk("stream_ready", 64'(ex_ready), 64'd1);
      chk("stream_pending", 64'(pending_mask), 64'(m1(i + 8)));
    end
    idle_in();
    tick();
    wb_accept = 1'b0;
    chk("stream_drained", 64'(can_writeback), 64'd0);

    // sim_end gating
    offer(mk(8'h01, 8'd0, 8'd1, 1'b0), 1);
    tick();
    offer(mk(8'h01, 8'd0, 8'd2, 1'b1), 1);
    tick();
    chk("simend_seen", 64'(sim_end_seen), 64'd1);
    chk("simend_full_ready", 64'(ex_ready), 64'd0);
    offer(mk(8'h01, 8'd0, 8'd3, 1'b0), 0);
    wb_accept = 1'b1;
    tick();
    chk("simend_one_ready", 64'(ex_ready), 64'd0);
    chk("simend_one_rm", 64'(exwb.ctl_rmByte), 64'd2);
    tick();
    chk("simend_empty_ready", 64'(ex_ready), 64'd0);
    chk("simend_empty_can_wb", 64'(can_writeback), 64'd0);
    tick();
    chk("simend_no_push", 64'(can_writeback), 64'd0);
    idle_in();
    wb_accept = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst2_sim_end", 64'(sim_end_seen), 64'd0);
    chk("rst2_can_wb", 64'(can_writeback), 64'd0);

    // reset mid-operation discards the buffered entry
    offer(mk(8'h01, 8'd0, 8'd8, 1'b0), 0);
    tick();
    idle_in();
    chk("midrst_loaded", 64'(can_writeback), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_can_wb", 64'(can_writeback), 64'd0);
    chk("midrst_pending", 64'(pending_mask), 64'd0);
    chk("midrst_exwb", 64'(exwb), 64'd0);
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
